multi_chan_counter: RTL and testbench
=====================================

MULTI_CHAN_COUNTER -- requirements
Module: multi_chan_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bit width of each channel count.
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving the number of independent counter channels (1..16).
REQ-003 The block SHALL have parameter DEC_COUNT, default 2, giving the per-cycle decrement step (1..2^WIDTH-1).
REQ-004 The block SHALL have port clock, input, 1, single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port in, input, CHANNELS*WIDTH, load values; channel c uses bits [c*WIDTH +: WIDTH].
REQ-007 The block SHALL have port latch, input, CHANNELS, per-channel load strobe.
REQ-008 The block SHALL have port dec, input, CHANNELS, per-channel decrement enable.
REQ-009 The block SHALL have port count, output, CHANNELS*WIDTH, current channel counts, same packing as in.
REQ-010 The block SHALL have port zero, output, CHANNELS, high while the channel count equals 0.
REQ-011 The block SHALL have port done, output, CHANNELS, one-cycle pulse when a decrement takes a channel from nonzero to 0.

Function
REQ-012 Each channel SHALL run an independent three-state FSM: IDLE (after reset), RUN (after a latch), EXPIRED (count reached 0 by decrement).
REQ-013 latch[c]=1 at a rising edge SHALL load count[c] from in[c] and move the channel to RUN from any state, one cycle latency.
REQ-014 latch SHALL take priority over dec when both are high in the same cycle; the decrement is discarded.
REQ-015 In RUN with dec[c]=1 and latch[c]=0: count >= DEC_COUNT SHALL give count-DEC_COUNT; count < DEC_COUNT SHALL give 0 (saturating, never wrapping below 0).
REQ-016 A RUN decrement that produces 0 SHALL move the channel to EXPIRED and assert done[c] for exactly the cycle in which count[c] first reads 0.
REQ-017 Loading in=0 SHALL give count 0 and zero=1, stay in RUN and raise no done pulse.
REQ-018 dec in IDLE SHALL have no effect; dec in EXPIRED SHALL behave as set by REQ-024/REQ-025.
REQ-019 zero[c] SHALL be decoded combinationally from the registered count[c]; count and done SHALL be registered outputs.
REQ-020 Channels SHALL not interact; any mix of latch/dec across channels in one cycle SHALL be handled in parallel.

Reset
REQ-021 reset=1 SHALL immediately, without waiting for a clock edge, force all counts to 0, all done to 0 and all FSMs to IDLE; zero therefore reads all-ones.
REQ-022 reset asserted mid-count SHALL abort the count with no done pulse; after release, the first latch SHALL act normally on the next rising edge.
REQ-023 The reload shadow registers (REQ-024) SHALL reset to 0.

Configuration
REQ-024 With macro COUNTER_AUTORELOAD_EN defined, each channel SHALL hold a shadow copy of its last latched value; dec[c]=1 in EXPIRED SHALL reload count[c] from the shadow and return to RUN, one cycle latency; a shadow of 0 SHALL keep the channel in EXPIRED at 0.
REQ-025 Without COUNTER_AUTORELOAD_EN, no shadow registers SHALL exist and EXPIRED SHALL hold count 0 regardless of dec until the next latch or reset.

Verification (WIDTH=4, CHANNELS=2, DEC_COUNT=2)
REQ-026 Ch0 latch in=4'b1100, then dec held high -> count 12,10,8,6,4,2,0 on successive edges; done[0] high only in the cycle count=0; zero[0] stays 1 after.
REQ-027 Ch1 latch 5, dec held high -> 5,3,1,0 (saturated, no wrap to 15); one done pulse; further dec holds 0 (macro undefined).
REQ-028 Ch0 latch=1 and dec=1 together with in=9 -> count 9 next cycle, no decrement; ch1 decrementing in the same cycles is unaffected.
REQ-029 Ch0 loaded with 8, two decrements, then reset pulsed between clock edges -> count 0, zero=1, done=0 before the next edge; no done pulse follows.
REQ-030 With COUNTER_AUTORELOAD_EN: ch0 latch 4, dec held high -> 4,2,0,4,2,0 with done on each 0; without the macro -> 4,2,0,0,0.

Source files
------------

// File: rtl/multi_chan_counter.sv
// multi_chan_counter: per-channel loadable saturating down-counters; define COUNTER_AUTORELOAD_EN to reload from the last latched value on dec in EXPIRED
module multi_chan_counter #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 2,
  parameter int DEC_COUNT = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       latch,
  input  logic [CHANNELS-1:0]       dec,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       done
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(DEC_COUNT);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, ld, sub;
    logic             done_d, run_dec, rel, hit;
    assign ld      = in[c*WIDTH +: WIDTH];
    assign sub     = cnt_q >= STEP ? cnt_q - STEP : '0;
    assign run_dec = dec[c] && state_q == RUN;
    assign hit     = run_dec && sub == '0;
`ifdef COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] shadow_q;
    assign rel = dec[c] && state_q == EXPIRED;
    // shadow keeps the most recent latched value for reloads
    always_ff @(posedge clock or posedge reset)
      if (reset) shadow_q <= '0;
      else if (latch[c]) shadow_q <= ld;
    // latch wins over dec; dec saturates at 0 in RUN and reloads in EXPIRED
    always_comb begin
      cnt_d   = latch[c] ? ld : run_dec ? sub : rel ? shadow_q : cnt_q;
      state_d = latch[c] ? RUN : hit ? EXPIRED : rel && shadow_q != '0 ? RUN : state_q;
      done_d  = !latch[c] && hit && cnt_q != '0;
    end
`else
    assign rel = 1'b0;
    // latch wins over dec; dec saturates at 0 in RUN, EXPIRED holds 0
    always_comb begin
      cnt_d   = latch[c] ? ld : run_dec ? sub : cnt_q;
      state_d = latch[c] ? RUN : hit ? EXPIRED : state_q;
      done_d  = !latch[c] && hit && cnt_q != '0 && !rel;
    end
`endif
    // channel state, count and done pulse registers
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        done[c] <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done[c] <= done_d;
      end
    assign count[c*WIDTH +: WIDTH] = cnt_q;
    assign zero[c] = cnt_q == '0;
  end
endmodule

// File: tb/tb_multi_chan_counter.sv
// tb_multi_chan_counter: directed checks of the two-channel counter with DEC_COUNT=2
module tb_multi_chan_counter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in    = '0;
  logic [1:0] latch = '0;
  logic [1:0] dec   = '0;
  logic [7:0] count;
  logic [1:0] zero, done;
  int checks = 0;
  int errors = 0;

  multi_chan_counter #(.WIDTH(4), .CHANNELS(2), .DEC_COUNT(2)) dut (
    .clock(clock), .reset(reset), .in(in), .latch(latch), .dec(dec),
    .count(count), .zero(zero), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk0(input string tag, input int c, input int d);
    chk({tag, " cnt0"}, 32'(count[3:0]), 32'(c));
    chk({tag, " zero0"}, 32'(zero[0]), 32'(c == 0));
    chk({tag, " done0"}, 32'(done[0]), 32'(d));
  endtask

  task automatic chk1(input string tag, input int c, input int d);
    chk({tag, " cnt1"}, 32'(count[7:4]), 32'(c));
    chk({tag, " zero1"}, 32'(zero[1]), 32'(c == 0));
    chk({tag, " done1"}, 32'(done[1]), 32'(d));
  endtask

  initial begin
    int seq0[6];
    int auto_en;
`ifdef COUNTER_AUTORELOAD_EN
    auto_en = 1;
`else
    auto_en = 0;
`endif
    seq0 = '{10, 8, 6, 4, 2, 0};
    #2;
    chk("rst count", 32'(count), 0);
    chk("rst zero", 32'(zero), 3);
    chk("rst done", 32'(done), 0);
    @(negedge clock);
    reset = 1'b0;
    // countdown from 12 on ch0
    in = 8'h0C; latch = 2'b01;
    tick;
    chk0("ld12", 12, 0);
    chk1("ld12 idle", 0, 0);
    latch = 2'b00; dec = 2'b01;
    foreach (seq0[i]) begin
      tick;
      chk0("dn12", seq0[i], seq0[i] == 0);
    end
    dec = 2'b00;
    tick;
    chk0("hold0", 0, 0);
    // ch1 saturates 5,3,1,0
    in = 8'h50; latch = 2'b10;
    tick;
    chk1("ld5", 5, 0);
    latch = 2'b00; dec = 2'b10;
    tick; chk1("dn5a", 3, 0);
    tick; chk1("dn5b", 1, 0);
    tick; chk1("dn5c", 0, 1);
    tick; chk1("dn5d", auto_en ? 5 : 0, 0);
    dec = 2'b00;
    // latch beats dec on ch0 while ch1 keeps decrementing
    in = 8'h70; latch = 2'b10;
    tick;
    chk1("ld7", 7, 0);
    in = 8'h09; latch = 2'b01; dec = 2'b11;
    tick;
    chk0("prio", 9, 0);
    chk1("par", 5, 0);
    latch = 2'b00;
    tick;
    chk0("prio dn", 7, 0);
    chk1("par dn", 3, 0);
    dec = 2'b00;
    // async reset mid-count
    in = 8'h08; latch = 2'b01;
    tick;
    latch = 2'b00; dec = 2'b01;
    tick; chk0("r8a", 6, 0);
    tick; chk0("r8b", 4, 0);
    #3;
    reset = 1'b1;
    #1;
    chk0("async rst", 0, 0);
    chk1("async rst", 0, 0);
    @(negedge clock);
    reset = 1'b0;
    tick;
    chk0("idle dec", 0, 0);
    in = 8'h03; latch = 2'b01; dec = 2'b00;
    tick;
    chk0("post rst ld", 3, 0);
    latch = 2'b00; dec = 2'b01;
    tick; chk0("pr dn a", 1, 0);
    tick; chk0("pr dn b", 0, 1);
    dec = 2'b00;
    // load of 0 on ch1
    in = 8'h00; latch = 2'b10;
    tick;
    chk1("ld0", 0, 0);
    latch = 2'b00; dec = 2'b10;
    tick;
    chk1("ld0 dec", 0, 0);
    dec = 2'b00;
    // expiry behaviour with dec held
    in = 8'h04; latch = 2'b01;
    tick;
    chk0("ld4", 4, 0);
    latch = 2'b00; dec = 2'b01;
    tick; chk0("e4a", 2, 0);
    tick; chk0("e4b", 0, 1);
    tick; chk0("e4c", auto_en ? 4 : 0, 0);
    tick; chk0("e4d", auto_en ? 2 : 0, 0);
    tick; chk0("e4e", 0, auto_en);
    dec = 2'b00;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
